// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode encodings,
// controller states and the default operand width.
package mips_muldiv_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Even encodings are the signed variants.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX-stage controller and the multiply/divide unit.
interface ex_muldiv_if #(parameter int W = 32);

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wehi;
    logic         welo;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    modport master (
        output start, op, a, b, wehi, welo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, wehi, welo, wdata,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/muldiv_core.sv
// Radix-2 datapath shared by multiply (shift-add) and restoring divide.
// Works on unsigned magnitudes; sign handling lives in the caller.
module muldiv_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc,
    output logic           last
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   addend;
    logic           mode_div;
    logic [CW-1:0]  cnt;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] shifted;
    logic [2*W-1:0] acc_step;

    // Multiply keeps {product_hi, multiplier} and shifts right; divide keeps
    // {remainder, quotient} and shifts left. Both consume one bit per step.
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
        shifted  = acc << 1;
        diff     = acc[2*W-1:W-1] - {1'b0, addend};
        acc_step = acc;
        if (mode_div) begin
            if (!diff[W])
                acc_step = {diff[W-1:0], shifted[W-1:1], 1'b1};
            else
                acc_step = shifted;
        end else begin
            if (acc[0])
                acc_step = {sum, acc[W-1:1]};
            else
                acc_step = {1'b0, acc[2*W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            addend   <= '0;
            mode_div <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= is_div ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
            addend   <= is_div ? b : a;
            mode_div <= is_div;
            cnt      <= CW'(W);
        end else if (step) begin
            acc      <= acc_step;
            cnt      <= cnt - CW'(1);
        end
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// also services MTHI/MTLO while idle.
module ex_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_muldiv_if.slave bus
);

    state_e         state;
    state_e         next_state;
    logic           load;
    logic           step;
    logic           last;
    logic [2*W-1:0] acc;

    logic           signed_op;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    logic           is_div_q;
    logic           neg_q;
    logic           neg_r;
    logic           bzero_q;

    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           done_q;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    assign signed_op = is_signed_op(bus.op);
    assign a_neg     = signed_op & bus.a[W-1];
    assign b_neg     = signed_op & bus.b[W-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    muldiv_core #(.W(W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (bus.op[1]),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (acc),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (last)
                    next_state = S_FIX;
            end
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The remainder follows the dividend's sign; with a zero divisor the
    // restoring loop leaves |A| in the remainder, so this also restores raw A.
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div_q <= bus.op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        bzero_q  <= (bus.b == '0);
                    end else begin
                        if (bus.wehi) hi_q <= bus.wdata;
                        if (bus.welo) lo_q <= bus.wdata;
                    end
                end
                S_FIX: begin
                    done_q <= 1'b1;
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= bzero_q ? '1 : quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: arithmetic reference model checked every
// cycle, plus directed vectors with literal results and latency checks.
module tb_ex_muldiv;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   cmpEn;

    ex_muldiv_if #(.W(W)) bus ();

    ex_muldiv #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the architectural definition of each op.
    function automatic logic [63:0] modelResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        int     r;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycle model: an accepted op occupies the unit for W+1 edges.
    int          mCnt;
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic        mDone;
    logic [63:0] mPend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCnt  = 0;
            mHi   = '0;
            mLo   = '0;
            mDone = 1'b0;
            mPend = '0;
        end else begin
            mDone = 1'b0;
            if (mCnt > 0) begin
                mCnt--;
                if (mCnt == 0) begin
                    {mHi, mLo} = mPend;
                    mDone      = 1'b1;
                end
            end else if (bus.start) begin
                mPend = modelResult(bus.op, bus.a, bus.b);
                mCnt  = W + 1;
            end else begin
                if (bus.wehi) mHi = bus.wdata;
                if (bus.welo) mLo = bus.wdata;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn && rst_n) begin
            checkOutput("cyc_busy", 64'(bus.busy), 64'(mCnt != 0));
            checkOutput("cyc_done", 64'(bus.done), 64'(mDone));
            checkOutput("cyc_hi", 64'(bus.hi), 64'(mHi));
            checkOutput("cyc_lo", 64'(bus.lo), 64'(mLo));
            checkOutput("cyc_done_busy", 64'(bus.done & bus.busy), 64'd0);
        end
    end

    // Launch one op and wait for Done; optionally disturb it mid-CALC with a
    // Start+MTHI, or pair the Start with an MTLO in the same idle cycle.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int disturbAt, input bit withWe);
        int edges;
        int busyCnt;
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        bus.welo  = withWe;
        bus.wdata = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        bus.welo  = 1'b0;
        edges     = 0;
        busyCnt   = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busyCnt++;
            if (disturbAt != 0 && edges == disturbAt) begin
                bus.start = 1'b1;
                bus.wehi  = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd5;
                bus.b     = 32'd1;
                bus.wdata = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.wehi  = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        bus.wehi  = 1'b0;
        checkOutput({name, "_latency"}, 64'(edges), 64'd33);
        checkOutput({name, "_busy_cycles"}, 64'(busyCnt), 64'd33);
        checkOutput({name, "_hi"}, 64'(bus.hi), 64'(expHi));
        checkOutput({name, "_lo"}, 64'(bus.lo), 64'(expLo));
        checkOutput({name, "_model"}, {mHi, mLo}, {expHi, expLo});
    endtask

    task automatic writeHiLo(input bit wh, input bit wl, input logic [31:0] data);
        @(negedge clk);
        bus.wehi  = wh;
        bus.welo  = wl;
        bus.wdata = data;
        @(negedge clk);
        bus.wehi  = 1'b0;
        bus.welo  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cmpEn     = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.wehi  = 1'b0;
        bus.welo  = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        #2 rst_n = 1'b1;
        cmpEn = 1'b1;

        applyStimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        applyStimulus("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        applyStimulus("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
        applyStimulus("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        applyStimulus("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0);
        applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
        applyStimulus("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("div_zero", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
        applyStimulus("busy_ignore", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0);
        applyStimulus("start_we", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1);

        writeHiLo(1'b1, 1'b1, 32'h1357_2468);
        checkOutput("mt_both", {bus.hi, bus.lo}, {32'h1357_2468, 32'h1357_2468});

        // Abort a MULT ten cycles in with an asynchronous reset.
        @(negedge clk);
        bus.op    = OP_MULT;
        bus.a     = 32'd1234;
        bus.b     = 32'd5678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_done", 64'(bus.done | bus.busy), 64'd0);
        end
        #2 rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(bus.done), 64'd0);
        end
        writeHiLo(1'b0, 1'b1, 32'hA5A5_A5A5);
        checkOutput("mtlo_after_abort", {bus.hi, bus.lo}, {32'd0, 32'hA5A5_A5A5});

        @(negedge clk);
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
